serial_word_link: RTL and testbench
===================================

# serial_word_link

Parallel-to-serial transmitter and serial-to-parallel receiver for the bit-serial datapath. It accepts an N-bit word through a valid/ready handshake and clears the downstream serial processing element (e.g. the serial two's complement converter) with a one-cycle pulse. It then shifts the word out LSB-first and collects the returned LSB-first serial stream back into a parallel result. It is the word-level front/back end for any single-bit serial FSM in the datapath.

## Interface
- WIDTH, 8, word width in bits (2..32)
- RET_LAT, 1, cycles from driving a bit on ser_out to its result being valid on ser_in (1..3)

- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-high
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  word to transmit
- ser_clr  output  1  one-cycle clear pulse to the downstream serial element (drives its reset)
- ser_out  output  1  serial bit to downstream, LSB first
- ser_in  input  1  serial bit returned from downstream, LSB first
- out_valid  output  1  one-cycle pulse, out_data updated
- out_data  output  WIDTH  collected result word
- busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE: in_ready=1. If in_valid=1, latch in_data into the shift register, go to CLR. Later changes on in_data are ignored.
- CLR (1 cycle): ser_clr=1, ser_out=0. Clear the bit counter and the capture register, then go to SHIFT.
- SHIFT (WIDTH cycles): ser_out=shreg[0]. Shift right each cycle. Assert an internal bit strobe. Go to DRAIN after bit WIDTH-1.
- DRAIN (RET_LAT cycles): ser_out=0, waiting for the last returned bit.
- Capture: the bit strobe is delayed by a RET_LAT-stage pipeline. On each delayed strobe, cap <= {ser_in, cap[WIDTH-1:1]}, so bit k returned lands in cap[k] after WIDTH captures. ser_in is ignored when no delayed strobe is present.
- DONE (1 cycle): out_data <= cap, out_valid=1, then go to IDLE. out_data holds its value until the next DONE or reset.
- in_ready=0 in every state except IDLE; in_valid outside IDLE has no effect.
- ser_out=0 and ser_clr=0 outside SHIFT and CLR respectively.
- No backpressure on the output: the consumer must take out_data on the out_valid cycle or read the held value later.

## Timing
- Cycle t = cycle with in_valid=1 and in_ready=1 (sampled at the closing edge).
- ser_clr high during t+1.
- Bit k on ser_out during t+2+k, for k=0..WIDTH-1.
- Returned bit k sampled from ser_in at the end of cycle t+2+k+RET_LAT.
- out_valid high during t+2+WIDTH+RET_LAT; IDLE at t+3+WIDTH+RET_LAT.
- Back-to-back throughput: one word per WIDTH+3+RET_LAT cycles (12 for WIDTH=8, RET_LAT=1).
- Reset (any state, including mid-SHIFT/DRAIN): at the next edge go to IDLE. The delay pipeline, counter, shreg and cap clear to 0; out_data=0, out_valid=0, ser_out=0, ser_clr=0, busy=0.
- in_ready=1 in the first cycle after reset deasserts, and is forced to 0 while reset=1.
- A word aborted by reset produces no out_valid pulse.

## Test plan
- Reset, then idle for 5 cycles: all outputs 0 except in_ready=1; ser_clr never pulses.
- WIDTH=8, RET_LAT=1, ser_in = ser_out delayed by one flop; send 0xA5 at t: ser_clr at t+1, ser_out 1,0,1,0,0,1,0,1 over t+2..t+9, out_valid at t+11 with out_data=0xA5.
- Same config, ser_clr/ser_out/ser_in wired to the serial two's complement converter: 0x05->0xFB, 0x01->0xFF, 0x00->0x00, 0x80->0x80, 0x7F->0x81.
- Back-to-back: in_valid held high with 0x03 then 0x10: accepts at t and t+12, results 0xFD at t+11 and 0xF0 at t+23; in_valid during busy is never accepted.
- Assert reset at t+5 during SHIFT: IDLE next cycle, no out_valid, out_data=0; a following word 0x22 completes normally with 0xDE.
- RET_LAT=3 with a 3-flop loopback, 0x5A: out_valid at t+13, out_data=0x5A.

Source files
------------

// File: rtl/serial_word_link.sv
// Word-level front/back end for a single-bit serial processing element:
// shifts a word out LSB-first, then reassembles the returned serial stream.
module serial_word_link #(
  parameter int WIDTH   = 8,
  parameter int RET_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_clr,
  output logic             ser_out,
  input  logic             ser_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

  localparam int CW = $clog2(WIDTH + RET_LAT);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(RET_LAT - 1);

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   cap;
  logic [WIDTH-1:0]   cap_next;
  logic [RET_LAT-1:0] dly;
  logic               strobe;
  logic               cap_en;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    ser_clr    = 1'b0;
    ser_out    = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    strobe     = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = !reset;
        if (in_valid) state_next = CLR;
      end
      CLR: begin
        ser_clr    = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        ser_out = shreg[0];
        strobe  = 1'b1;
        if (cnt == LAST_BIT) state_next = DRAIN;
      end
      DRAIN: begin
        if (cnt == LAST_DRAIN) state_next = DONE;
      end
      DONE: begin
        out_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The bit strobe travels through the same latency as the downstream loop,
  // so the capture register only samples ser_in when a returned bit is due.
  assign cap_en   = dly[RET_LAT-1];
  assign cap_next = cap_en ? {ser_in, cap[WIDTH-1:1]} : cap;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      shreg    <= '0;
      cap      <= '0;
      dly      <= '0;
      out_data <= '0;
    end else begin
      dly[0] <= strobe;
      for (int i = 1; i < RET_LAT; i++) dly[i] <= dly[i-1];
      cap <= cap_next;
      case (state)
        IDLE: begin
          if (in_valid) shreg <= in_data;
        end
        CLR: begin
          cnt <= '0;
          cap <= '0;
        end
        SHIFT: begin
          shreg <= shreg >> 1;
          cnt   <= (cnt == LAST_BIT) ? '0 : cnt + 1'b1;
        end
        DRAIN: begin
          cnt <= cnt + 1'b1;
          // The last returned bit arrives on this edge, so take it directly.
          if (cnt == LAST_DRAIN) out_data <= cap_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_link.sv
// Bench for serial_word_link: a RET_LAT=1 instance looped back or feeding a
// serial two's complement converter, and a RET_LAT=3 instance with a 3-flop loop.
module tb_serial_word_link;

  logic       clk = 1'b0;
  logic       reset;
  logic       drv_valid;
  logic [7:0] drv_data;
  logic       sel;
  logic       conv;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         last_acc = 0;
  logic [7:0] last_exp;

  logic       in_valid1, in_ready1, ser_clr1, ser_out1, ser_in1, out_valid1, busy1;
  logic [7:0] out_data1;
  logic       in_valid3, in_ready3, ser_clr3, ser_out3, ser_in3, out_valid3, busy3;
  logic [7:0] out_data3;

  logic       lb1, cq, seen;
  logic [2:0] lb3;

  logic       o_ready, o_clr, o_sout, o_valid, o_busy;
  logic [7:0] o_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign in_valid1 = drv_valid & ~sel;
  assign in_valid3 = drv_valid & sel;

  serial_word_link #(.WIDTH(8), .RET_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(drv_data), .ser_clr(ser_clr1), .ser_out(ser_out1), .ser_in(ser_in1),
    .out_valid(out_valid1), .out_data(out_data1), .busy(busy1)
  );

  serial_word_link #(.WIDTH(8), .RET_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(drv_data), .ser_clr(ser_clr3), .ser_out(ser_out3), .ser_in(ser_in3),
    .out_valid(out_valid3), .out_data(out_data3), .busy(busy3)
  );

  // Downstream environment: plain loopbacks and a serial two's complement
  // converter (copy bits up to and including the first 1, invert the rest).
  always @(posedge clk) begin
    lb1 <= ser_out1;
    lb3 <= {lb3[1:0], ser_out3};
    if (ser_clr1) begin
      seen <= 1'b0;
      cq   <= 1'b0;
    end else begin
      cq   <= ser_out1 ^ seen;
      seen <= seen | ser_out1;
    end
  end

  assign ser_in1 = conv ? cq : lb1;
  assign ser_in3 = lb3[2];

  assign o_ready = sel ? in_ready3  : in_ready1;
  assign o_clr   = sel ? ser_clr3   : ser_clr1;
  assign o_sout  = sel ? ser_out3   : ser_out1;
  assign o_valid = sel ? out_valid3 : out_valid1;
  assign o_busy  = sel ? busy3      : busy1;
  assign o_data  = sel ? out_data3  : out_data1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    drv_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      checkOutput("idle_ready", o_ready, 1);
      checkOutput("idle_valid", o_valid, 0);
      checkOutput("out_hold", o_data, last_exp);
    end
  endtask

  // One word through the selected instance; expectation is the word itself
  // or its arithmetic negation when routed through the converter.
  task automatic applyStimulus(input logic [7:0] data, input bit use_conv, input bit b2b);
    int n;
    int t;
    int c;
    int rl;
    logic [8:0] neg;
    logic [7:0] expv;
    rl   = sel ? 3 : 1;
    neg  = 9'h100 - {1'b0, data};
    expv = use_conv ? neg[7:0] : data;
    conv = use_conv;
    drv_data  = data;
    drv_valid = 1'b1;
    n = 0;
    while (o_ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_wait", n < 30, 1);
    t = cyc;
    if (b2b) checkOutput("b2b_spacing", t - last_acc, 8 + 3 + rl);
    last_acc = t;
    @(posedge clk);
    @(negedge clk);
    c = 1;
    drv_data = 8'($urandom);
    checkOutput("clr_pulse", o_clr, 1);
    checkOutput("clr_ser_out", o_sout, 0);
    checkOutput("busy_ready", {o_busy, o_ready}, 2'b10);
    while (o_valid !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
      drv_data = 8'($urandom);
      if (c == 2) checkOutput("clr_once", o_clr, 0);
      if (c >= 2 && c <= 9) checkOutput("ser_out_bit", o_sout, data[c-2]);
    end
    checkOutput("out_latency", c, 10 + rl);
    checkOutput("out_data", o_data, expv);
    checkOutput("done_ready", o_ready, 0);
    drv_valid = 1'b0;
    last_exp  = expv;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pulses;
    reset = 1'b1;
    drv_valid = 1'b0;
    drv_data = 8'h00;
    sel = 1'b0;
    conv = 1'b0;
    last_exp = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("ready_forced_low", {in_ready1, in_ready3}, 2'b00);
    reset = 1'b0;
    #1 checkOutput("ready_after_reset", {in_ready1, in_ready3}, 2'b11);
    repeat (5) begin
      @(negedge clk);
      checkOutput("reset_idle_outputs",
                  {ser_clr1, ser_out1, out_valid1, busy1, out_data1, in_ready1}, 13'h1);
    end

    $display("[TB] loopback 0xA5");
    applyStimulus(8'hA5, 1'b0, 1'b0);
    idleCycles(2);

    $display("[TB] converter directed words");
    applyStimulus(8'h05, 1'b1, 1'b0); idleCycles(1);
    applyStimulus(8'h01, 1'b1, 1'b0); idleCycles(1);
    applyStimulus(8'h00, 1'b1, 1'b0); idleCycles(1);
    applyStimulus(8'h80, 1'b1, 1'b0); idleCycles(1);
    applyStimulus(8'h7F, 1'b1, 1'b0); idleCycles(1);

    $display("[TB] back-to-back");
    applyStimulus(8'h03, 1'b1, 1'b0);
    applyStimulus(8'h10, 1'b1, 1'b1);
    idleCycles(2);

    $display("[TB] reset during SHIFT");
    conv = 1'b1;
    drv_data = 8'h5C;
    drv_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drv_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1 checkOutput("ready_in_reset", o_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 checkOutput("abort_state",
                   {o_busy, o_valid, o_sout, o_clr, o_ready, o_data}, 13'h100);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_valid === 1'b1) pulses++;
    end
    checkOutput("abort_no_valid", pulses, 0);
    last_exp = 8'h00;
    applyStimulus(8'h22, 1'b1, 1'b0);
    idleCycles(1);

    $display("[TB] random words, RET_LAT=1");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      idleCycles(1);
    end

    $display("[TB] RET_LAT=3 loopback");
    sel = 1'b1;
    last_exp = 8'h00;
    @(negedge clk);
    applyStimulus(8'h5A, 1'b0, 1'b0);
    idleCycles(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'($urandom), 1'b0, 1'b0);
      idleCycles(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
